// File: rtl/pulse_syn_pkg.sv
// Shared constants and types for the multi-channel fast-to-slow pulse synchroniser.
package pulse_syn_pkg;

    // Legal synchroniser depth, used for both crossing directions
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int NCH_MAX         = 32;

    // Fast-side launch FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Per-channel status reported back to the top, all clk_fast domain
    typedef struct packed {
        logic busy;
        logic pend_nz;
        logic ovf;
    } ch_stat_t;

    // Saturation value of a pending counter of the given width
    function automatic int pend_sat(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/pulse_syn_multi_f2s_if.sv
// Event/status bundle of the pulse synchroniser. The master drives events and
// overflow clears; the slave (the synchroniser) returns pulses and status.
interface pulse_syn_multi_f2s_if
    import pulse_syn_pkg::*;
#(
    parameter int NCH = 4
);
    logic [NCH-1:0] pulse_fast;
    logic [NCH-1:0] ovf_clr;
    logic [NCH-1:0] pulse_slow;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] pend_nz;
    logic [NCH-1:0] ovf;

    modport master (
        output pulse_fast, ovf_clr,
        input  pulse_slow, busy, pend_nz, ovf
    );

    modport slave (
        input  pulse_fast, ovf_clr,
        output pulse_slow, busy, pend_nz, ovf
    );
endinterface

// File: rtl/pulse_syn_f2s_ch.sv
// One channel: pending-event counter and IDLE/WAIT launch FSM in clk_fast,
// req toggle synchronised into clk_slow, history flop returned as ack toggle.
module pulse_syn_f2s_ch
    import pulse_syn_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic     rstn,
    input  logic     clk_fast,
    input  logic     clk_slow,
    input  logic     pulse_fast_i,
    input  logic     ovf_clr_i,
    output logic     pulse_slow_o,
    output ch_stat_t stat_o
);
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pend_sat(CNT_W));

    // clk_fast domain state
    logic [0:0]       state_q, state_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             drop;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync_q;
    logic             ack_s;

    // clk_slow domain state
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] req_sync_q;
    logic             hist_q;
    logic             pulse_q;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Launch/complete decisions and pending-counter update for one fast edge
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        pend_d  = pend_q;
        drop    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (pulse_fast_i || (pend_q != '0)) begin
                req_d   = ~req_q;
                state_d = ST_WAIT;
                // A fresh pulse is launched directly; otherwise a stored one is used
                if (!pulse_fast_i) pend_d = pend_q - 1'b1;
            end
        end else begin
            // Completion frees the channel; launch waits for the next edge
            if (ack_s == req_q) state_d = ST_IDLE;
            if (pulse_fast_i) begin
                if (pend_q == PEND_MAX) drop   = 1'b1;
                else                    pend_d = pend_q + 1'b1;
            end
        end
        // A drop on the same edge as a clear keeps the flag set
        ovf_d = (ovf_q & ~ovf_clr_i) | drop;
    end

    // Fast-side registers and ack toggle synchroniser
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], hist_q};
        end
    end

    // Slow side: synchronise req, keep last value, one pulse per toggle
    always_ff @(posedge clk_slow or negedge rstn) begin
        if (!rstn) begin
            req_sync_q <= '0;
            hist_q     <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
            hist_q     <= req_sync_q[SYNC_STAGES-1];
            pulse_q    <= req_sync_q[SYNC_STAGES-1] ^ hist_q;
        end
    end

    assign pulse_slow_o   = pulse_q;
    assign stat_o.busy    = (state_q == ST_WAIT);
    assign stat_o.pend_nz = (pend_q != '0);
    assign stat_o.ovf     = ovf_q;

endmodule

// File: rtl/pulse_syn_multi_f2s.sv
// Multi-channel fast-to-slow pulse synchroniser: NCH independent toggle
// handshake channels, each buffering bursts in a saturating pending counter.
module pulse_syn_multi_f2s
    import pulse_syn_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                  rstn,
    input  logic                  clk_fast,
    input  logic                  clk_slow,
    pulse_syn_multi_f2s_if.slave  io
);
    ch_stat_t [NCH-1:0] stat;
    logic     [NCH-1:0] pulse_slow_w;
    logic     [NCH-1:0] busy_w;
    logic     [NCH-1:0] pend_nz_w;
    logic     [NCH-1:0] ovf_w;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pulse_syn_f2s_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .rstn         (rstn),
            .clk_fast     (clk_fast),
            .clk_slow     (clk_slow),
            .pulse_fast_i (io.pulse_fast[i]),
            .ovf_clr_i    (io.ovf_clr[i]),
            .pulse_slow_o (pulse_slow_w[i]),
            .stat_o       (stat[i])
        );
        assign busy_w[i]    = stat[i].busy;
        assign pend_nz_w[i] = stat[i].pend_nz;
        assign ovf_w[i]     = stat[i].ovf;
    end

    assign io.pulse_slow = pulse_slow_w;
    assign io.busy       = busy_w;
    assign io.pend_nz    = pend_nz_w;
    assign io.ovf        = ovf_w;

endmodule
